// File: rtl/pool_max2x2.sv
// rtl/pool_max2x2.sv - 2x2 stride-2 signed max-pool over a raster conv/ReLU stream
// POOL_BINARIZE_EN: output +1/-1 against BIN_THR instead of the pooled value.
module pool_max2x2 #(
  parameter int DW = 32,
`ifdef POOL_BINARIZE_EN
  parameter logic signed [DW-1:0] BIN_THR = '0,
`endif
  parameter int W0 = 24,
  parameter int W1 = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          state,
  input  logic          ivalid,
  input  logic [DW-1:0] din,
  input  logic          idone,
  output logic          ovalid,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          frame_err
);
  localparam int CW = $clog2(W0);
  localparam int LD = W0 / 2;
  localparam logic [CW-1:0] LAST0 = CW'(W0 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(W1 - 1);

  logic [CW-1:0]        col_q, col_d, row_q, row_d;
  logic                 frame_act_q, frame_act_d, sel_q, sel_d;
  logic [DW-1:0]        hold_q, hold_d;
  logic [DW-1:0]        lbuf_q [LD];
  logic [DW-1:0]        lbuf_d [LD];
  logic                 ovalid_q, ovalid_d, done_q, done_d, frame_err_q, frame_err_d;
  logic [DW-1:0]        dout_q, dout_d;

  logic [CW-1:0]        last_idx;
  logic [CW-2:0]        lidx;
  logic                 at_last_col, at_last_row, frame_end;
  logic signed [DW-1:0] hmax, lmax, pmax, res;

  always_comb begin
    // Map size is captured from state on the first pixel and held for the frame.
    sel_d       = (ivalid && !frame_act_q) ? state : sel_q;
    last_idx    = sel_d ? LAST1 : LAST0;
    at_last_col = (col_q == last_idx);
    at_last_row = (row_q == last_idx);
    frame_end   = at_last_col && at_last_row;
    lidx        = col_q[CW-1:1];

    hmax = ($signed(din) > $signed(hold_q)) ? $signed(din) : $signed(hold_q);
    lmax = $signed(lbuf_q[lidx]);
    pmax = (lmax > hmax) ? lmax : hmax;
`ifdef POOL_BINARIZE_EN
    res  = (pmax > BIN_THR) ? DW'(1) : '1;
`else
    res  = pmax;
`endif

    col_d       = col_q;
    row_d       = row_q;
    frame_act_d = frame_act_q;
    hold_d      = hold_q;
    lbuf_d      = lbuf_q;
    ovalid_d    = 1'b0;
    dout_d      = '0;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    if (ivalid) begin
      frame_act_d = 1'b1;
      if (!col_q[0]) begin
        hold_d = din;
      end else if (!row_q[0]) begin
        lbuf_d[lidx] = hmax;
      end else begin
        ovalid_d = 1'b1;
        dout_d   = res;
        done_d   = frame_end;
      end

      // A premature idone aborts the frame after this pixel's own work is done.
      if (idone && !frame_end) begin
        frame_err_d = 1'b1;
        col_d       = '0;
        row_d       = '0;
        frame_act_d = 1'b0;
      end else if (at_last_col) begin
        col_d = '0;
        if (at_last_row) begin
          row_d       = '0;
          frame_act_d = 1'b0;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q       <= '0;
      row_q       <= '0;
      frame_act_q <= 1'b0;
      sel_q       <= 1'b0;
      ovalid_q    <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      frame_act_q <= frame_act_d;
      sel_q       <= sel_d;
      ovalid_q    <= ovalid_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    lbuf_q <= lbuf_d;
  end

  assign ovalid    = ovalid_q;
  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_pool_max2x2.sv
// tb/tb_pool_max2x2.sv - directed-vector bench for pool_max2x2
module tb_pool_max2x2;
  logic        clk = 1'b0;
  logic        rstn;
  logic        state;
  logic        ivalid;
  logic [31:0] din;
  logic        idone;
  logic        ovalid;
  logic [31:0] dout;
  logic        done;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int img [576];

  pool_max2x2 dut (
    .clk(clk), .rstn(rstn), .state(state), .ivalid(ivalid), .din(din), .idone(idone),
    .ovalid(ovalid), .dout(dout), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic int exp_max(int w, int r, int c);
    int m;
    m = img[(r-1)*w + c-1];
    if (img[(r-1)*w + c] > m) m = img[(r-1)*w + c];
    if (img[r*w + c-1] > m) m = img[r*w + c-1];
    if (img[r*w + c] > m) m = img[r*w + c];
    return m;
  endfunction

  function automatic int exp_out(int m);
`ifdef POOL_BINARIZE_EN
    return (m > 0) ? 1 : -1;
`else
    return m;
`endif
  endfunction

  task automatic send(input int d, input bit id, output bit ov, output logic [31:0] od,
                      output bit odn, output bit oer);
    @(negedge clk);
    ivalid = 1'b1; din = d; idone = id;
    @(posedge clk); #1;
    ov = ovalid; od = dout; odn = done; oer = frame_err;
    ivalid = 1'b0; idone = 1'b0;
  endtask

  task automatic idle(output bit ov, output logic [31:0] od);
    @(negedge clk);
    ivalid = 1'b0;
    @(posedge clk); #1;
    ov = ovalid; od = dout;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b want=0", ovalid); end
    total++; if (dout !== 32'd0) begin bad++; $display("FAIL reset_dout got=%0h want=0", dout); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_raster();
    bit ov, odn, oer, ev;
    logic [31:0] od;
    int r, c, nout;
    nout = 0;
    state = 1'b0;
    for (int p = 0; p < 576; p++) begin
      r = p / 24; c = p % 24;
      ev = (r % 2 == 1) && (c % 2 == 1);
      send(p, p == 575, ov, od, odn, oer);
      total++; if (ov !== ev) begin bad++; $display("FAIL raster_ovalid p=%0d got=%b want=%b", p, ov, ev); end
      if (ev) begin
        nout++;
        total++;
        if (od !== 32'(exp_out((2*(r/2)+1)*24 + 2*(c/2) + 1))) begin
          bad++; $display("FAIL raster_dout k=%0d got=%0d want=%0d", nout, od, exp_out((2*(r/2)+1)*24 + 2*(c/2) + 1));
        end
        total++; if (odn !== (nout == 144)) begin bad++; $display("FAIL raster_done k=%0d got=%b want=%b", nout, odn, nout == 144); end
      end
      if (p == 575) begin
        total++; if (oer !== 1'b0) begin bad++; $display("FAIL raster_err got=%b want=0", oer); end
      end
    end
    total++; if (nout != 144) begin bad++; $display("FAIL raster_count got=%0d want=144", nout); end
  endtask

  task automatic test_gaps_state_toggle();
    bit ov, odn, oer, ev;
    logic [31:0] od;
    int r, c, nout;
    nout = 0;
    state = 1'b1;
    for (int p = 0; p < 64; p++) img[p] = int'($urandom_range(1000));
    for (int p = 0; p < 64; p++) begin
      r = p / 8; c = p % 8;
      ev = (r % 2 == 1) && (c % 2 == 1);
      if (p == 20) state = 1'b0;
      send(img[p], 1'b0, ov, od, odn, oer);
      total++; if (ov !== ev) begin bad++; $display("FAIL gaps_ovalid p=%0d got=%b want=%b", p, ov, ev); end
      if (ev) begin
        nout++;
        total++; if (od !== 32'(exp_out(exp_max(8, r, c)))) begin bad++; $display("FAIL gaps_dout p=%0d got=%0d want=%0d", p, od, exp_out(exp_max(8, r, c))); end
        total++; if (odn !== (nout == 16)) begin bad++; $display("FAIL gaps_done k=%0d got=%b want=%b", nout, odn, nout == 16); end
      end
      for (int g = 0; g < 2; g++) begin
        idle(ov, od);
        total++; if (ov !== 1'b0 || od !== 32'd0) begin bad++; $display("FAIL gaps_idle p=%0d ovalid=%b dout=%0d want 0/0", p, ov, od); end
      end
    end
    total++; if (nout != 16) begin bad++; $display("FAIL gaps_count got=%0d want=16", nout); end
  endtask

  task automatic test_ties_signed();
    bit ov, odn, oer;
    logic [31:0] od;
    int want [3];
    state = 1'b1;
    for (int p = 0; p < 64; p++) img[p] = 0;
    img[0] = 5; img[1] = 9; img[8] = 3; img[9] = 9;
    img[2] = -7;
    img[16] = -7; img[17] = -3; img[24] = -9; img[25] = -2;
    want[0] = exp_out(9); want[1] = exp_out(0); want[2] = exp_out(-2);
    for (int p = 0; p < 64; p++) begin
      send(img[p], 1'b0, ov, od, odn, oer);
      if (p == 9 || p == 11 || p == 25) begin
        total++;
        if (ov !== 1'b1 || od !== 32'(want[p == 9 ? 0 : (p == 11 ? 1 : 2)])) begin
          bad++; $display("FAIL ties_dout p=%0d ovalid=%b got=%0d want=%0d", p, ov, $signed(od), want[p == 9 ? 0 : (p == 11 ? 1 : 2)]);
        end
      end
    end
  endtask

  task automatic test_frame_err();
    bit ov, odn, oer, ev;
    logic [31:0] od;
    int r, c, nout;
    state = 1'b1;
    for (int p = 0; p < 64; p++) img[p] = (p * 37) % 101;
    for (int p = 0; p <= 40; p++) begin
      r = p / 8; c = p % 8;
      ev = (r % 2 == 1) && (c % 2 == 1);
      send(img[p], p == 40, ov, od, odn, oer);
      total++; if (oer !== (p == 40)) begin bad++; $display("FAIL err_pulse p=%0d got=%b want=%b", p, oer, p == 40); end
      total++; if (odn !== 1'b0) begin bad++; $display("FAIL err_done p=%0d got=%b want=0", p, odn); end
      if (ev) begin
        total++; if (ov !== 1'b1 || od !== 32'(exp_out(exp_max(8, r, c)))) begin bad++; $display("FAIL err_dout p=%0d ovalid=%b got=%0d", p, ov, od); end
      end
    end
    nout = 0;
    for (int p = 0; p < 64; p++) img[p] = 500 - p * 7;
    for (int p = 0; p < 64; p++) begin
      r = p / 8; c = p % 8;
      ev = (r % 2 == 1) && (c % 2 == 1);
      send(img[p], p == 63, ov, od, odn, oer);
      total++; if (ov !== ev || oer !== 1'b0) begin bad++; $display("FAIL err_next_ovalid p=%0d got=%b/%b want=%b/0", p, ov, oer, ev); end
      if (ev) begin
        nout++;
        total++; if (od !== 32'(exp_out(exp_max(8, r, c)))) begin bad++; $display("FAIL err_next_dout p=%0d got=%0d want=%0d", p, od, exp_out(exp_max(8, r, c))); end
        total++; if (odn !== (nout == 16)) begin bad++; $display("FAIL err_next_done k=%0d got=%b", nout, odn); end
      end
    end
    total++; if (nout != 16) begin bad++; $display("FAIL err_next_count got=%0d want=16", nout); end
  endtask

  task automatic test_reset_mid_frame();
    bit ov, odn, oer, ev;
    logic [31:0] od;
    int r, c, nout;
    state = 1'b0;
    for (int p = 0; p < 288; p++) begin
      send(p, 1'b0, ov, od, odn, oer);
    end
    total++; if (ov !== 1'b1 || od === 32'd0) begin bad++; $display("FAIL rst_pre_ovalid got=%b dout=%0d want 1/nonzero", ov, od); end
    rstn = 1'b0;
    #1;
    total++; if (ovalid !== 1'b0 || dout !== 32'd0 || done !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_async ovalid=%b dout=%0d done=%b err=%b want all 0", ovalid, dout, done, frame_err);
    end
    @(negedge clk);
    rstn = 1'b1;
    state = 1'b1;
    nout = 0;
    for (int p = 0; p < 64; p++) img[p] = int'($urandom_range(1000));
    for (int p = 0; p < 64; p++) begin
      r = p / 8; c = p % 8;
      ev = (r % 2 == 1) && (c % 2 == 1);
      send(img[p], 1'b0, ov, od, odn, oer);
      total++; if (ov !== ev) begin bad++; $display("FAIL rst_next_ovalid p=%0d got=%b want=%b", p, ov, ev); end
      if (ev) begin
        nout++;
        total++; if (od !== 32'(exp_out(exp_max(8, r, c)))) begin bad++; $display("FAIL rst_next_dout p=%0d got=%0d want=%0d", p, od, exp_out(exp_max(8, r, c))); end
        total++; if (odn !== (nout == 16)) begin bad++; $display("FAIL rst_next_done k=%0d got=%b", nout, odn); end
      end
    end
    total++; if (nout != 16) begin bad++; $display("FAIL rst_next_count got=%0d want=16", nout); end
  endtask

`ifdef POOL_BINARIZE_EN
  task automatic test_binarize();
    bit ov, odn, oer;
    logic [31:0] od, want;
    int k;
    k = 0;
    state = 1'b1;
    for (int p = 0; p < 64; p++) begin
      if (p == 10) state = 1'b0;
      send(p == 3 ? 5 : 0, 1'b0, ov, od, odn, oer);
      if (ov) begin
        want = (k == 1) ? 32'd1 : 32'hFFFF_FFFF;
        total++; if (od !== want) begin bad++; $display("FAIL bin_dout k=%0d got=%0h want=%0h", k, od, want); end
        k++;
      end
    end
    total++; if (k != 16) begin bad++; $display("FAIL bin_count got=%0d want=16", k); end
  endtask
`endif

  initial begin
    rstn = 1'b0; state = 1'b0; ivalid = 1'b0; din = '0; idone = 1'b0;
    test_reset();
    test_raster();
    test_gaps_state_toggle();
    test_ties_signed();
    test_frame_err();
    test_reset_mid_frame();
`ifdef POOL_BINARIZE_EN
    test_binarize();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
